// File: rtl/sram_req_ctrl_if.sv
// rtl/sram_req_ctrl_if.sv - request, response and SRAM pin bundle for sram_req_ctrl
interface sram_req_ctrl_if #(
  parameter int ADR = 8,
  parameter int DAT = 8
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [ADR-1:0] req_addr;
  logic [DAT-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DAT-1:0] rsp_rdata;
  logic           rsp_err;
  logic           mem_CS;
  logic           mem_WE;
  logic           mem_RD;
  logic [ADR-1:0] mem_Addr;
  logic [DAT-1:0] mem_dataIn;
  logic [DAT-1:0] mem_dataOut;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dataOut,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_CS, mem_WE, mem_RD, mem_Addr, mem_dataIn
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dataOut,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_CS, mem_WE, mem_RD, mem_Addr, mem_dataIn
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - FIFO-buffered request sequencer for a single-port synchronous SRAM
module sram_req_ctrl #(
  parameter int ADR    = 8,
  parameter int DAT    = 8,
  parameter int DPTH   = 8,
  parameter int FDEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  sram_req_ctrl_if.slave            bus,
  output logic [$clog2(FDEPTH):0]   fifo_count_o
);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(FDEPTH);
  localparam logic [ADR:0]   DPTH_LIM = (ADR+1)'(DPTH);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_e;

  state_e             state_q;
  logic [ADR+DAT:0]   fifo_mem_q [FDEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [ADR-1:0]     cmd_addr_q;
  logic [DAT-1:0]     cmd_wdata_q;
  logic [DAT-1:0]     rsp_rdata_q;
  logic               rsp_err_q;

  logic               push;
  logic               pop;
  logic               head_we;
  logic [ADR-1:0]     head_addr;
  logic [DAT-1:0]     head_wdata;
  logic               head_oob;

  // Ready depends only on occupancy: a same-cycle pop never frees a slot early.
  assign bus.req_ready = rst_n_i && (count_q != FULL_CNT);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state_q == IDLE) && (count_q != '0);

  assign {head_we, head_addr, head_wdata} = fifo_mem_q[rd_ptr_q];
  assign head_oob = {1'b0, head_addr} >= DPTH_LIM;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {bus.req_we, bus.req_addr, bus.req_wdata};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            // Out-of-range commands leave the SRAM pins at their last access.
            if (!head_oob) begin
              cmd_addr_q  <= head_addr;
              cmd_wdata_q <= head_wdata;
            end
            rsp_rdata_q <= '0;
            rsp_err_q   <= head_oob;
            state_q     <= head_oob ? RESP : (head_we ? WRITE : READ);
          end
        end
        WRITE:   state_q <= RESP;
        READ:    state_q <= CAPTURE;
        CAPTURE: begin
          rsp_rdata_q <= bus.mem_dataOut;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_CS     = (state_q == WRITE) || (state_q == READ);
  assign bus.mem_WE     = (state_q == WRITE);
  assign bus.mem_RD     = (state_q == READ);
  assign bus.mem_Addr   = cmd_addr_q;
  assign bus.mem_dataIn = cmd_wdata_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign fifo_count_o   = count_q;
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed self-checking bench for sram_req_ctrl
module tb_sram_req_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fifo_count;
  int         errors = 0;
  int         checks = 0;
  int         both_cnt = 0;
  int         cs_cnt = 0;
  int         cs_base;
  logic [8:0] rsp_q [$];
  // Stored XOR-encoded so the power-up contents read back as addr ^ 8'h5A.
  logic [7:0] sram_x [256] = '{default: 8'h00};

  sram_req_ctrl_if #(.ADR(8), .DAT(8)) bus ();

  sram_req_ctrl #(.ADR(8), .DAT(8), .DPTH(8), .FDEPTH(4)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .bus          (bus),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_CS && bus.mem_WE) sram_x[bus.mem_Addr] <= bus.mem_dataIn ^ bus.mem_Addr ^ 8'h5A;
    if (bus.mem_CS && bus.mem_RD) bus.mem_dataOut <= sram_x[bus.mem_Addr] ^ bus.mem_Addr ^ 8'h5A;
  end

  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_err, bus.rsp_rdata});
    if (bus.mem_WE && bus.mem_RD) both_cnt++;
    if (bus.mem_CS) cs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("push_timeout", 32'(n), 32'd0);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 300) begin
      step();
      k++;
    end
    check("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [7:0] rdata);
    logic [8:0] v;
    v = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'h1FF;
    check(tag, {23'd0, v}, {23'd0, err, rdata});
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready", bus.req_ready, 0);
    check("rst_count", fifo_count, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_err", bus.rsp_err, 0);
    check("rst_strobes", {bus.mem_CS, bus.mem_WE, bus.mem_RD}, 0);
    check("rst_addr", bus.mem_Addr, 0);
    check("rst_din", bus.mem_dataIn, 0);
    rst_n = 1'b1;
    step();
    check("rel_ready", bus.req_ready, 1);

    // Write addr 3 = A5, then read it back, cycle-exact
    bus.rsp_ready = 1'b1;
    push(1'b1, 8'd3, 8'hA5);
    check("wr_e0_count", fifo_count, 1);
    check("wr_e0_cs", bus.mem_CS, 0);
    step();
    check("wr_e1_strobes", {bus.mem_CS, bus.mem_WE, bus.mem_RD}, 3'b110);
    check("wr_e1_addr", bus.mem_Addr, 3);
    check("wr_e1_din", bus.mem_dataIn, 8'hA5);
    check("wr_e1_count", fifo_count, 0);
    step();
    check("wr_e2_valid", bus.rsp_valid, 1);
    check("wr_e2_rsp", {bus.rsp_err, bus.rsp_rdata}, 0);
    check("wr_e2_cs", bus.mem_CS, 0);
    step();
    check("wr_e3_valid", bus.rsp_valid, 0);
    push(1'b0, 8'd3, 8'h00);
    step();
    check("rd_e1_strobes", {bus.mem_CS, bus.mem_WE, bus.mem_RD}, 3'b101);
    step();
    check("rd_e2_valid", bus.rsp_valid, 0);
    check("rd_e2_cs", bus.mem_CS, 0);
    step();
    check("rd_e3_valid", bus.rsp_valid, 1);
    check("rd_e3_rsp", {bus.rsp_err, bus.rsp_rdata}, {1'b0, 8'hA5});
    step();
    wait_q(2);
    expect_rsp("wr3_rsp", 1'b0, 8'h00);
    expect_rsp("rd3_rsp", 1'b0, 8'hA5);

    // Out-of-range read addr 8, then in-range read addr 7
    cs_base = cs_cnt;
    push(1'b0, 8'd8, 8'h00);
    check("oob_e0_cs", bus.mem_CS, 0);
    step();
    check("oob_e1_valid", bus.rsp_valid, 1);
    check("oob_e1_rsp", {bus.rsp_err, bus.rsp_rdata}, 9'h100);
    step();
    check("oob_no_cs", 32'(cs_cnt - cs_base), 0);
    push(1'b0, 8'd7, 8'h00);
    wait_q(2);
    expect_rsp("oob_rsp", 1'b1, 8'h00);
    expect_rsp("rd7_rsp", 1'b0, 8'h5D);

    // FIFO full with response stalled
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 8'(i), 8'(8'h10 + i));
    check("full_count", fifo_count, 4);
    check("full_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold_count", fifo_count, 4);
      check("full_hold_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    push(1'b0, 8'd2, 8'h00);
    wait_q(6);
    for (int i = 0; i < 5; i++) expect_rsp("full_wr_rsp", 1'b0, 8'h00);
    expect_rsp("full_rd2_rsp", 1'b0, 8'h12);

    // Backpressure on a read response
    bus.rsp_ready = 1'b0;
    push(1'b0, 8'd5, 8'h00);
    push(1'b1, 8'd6, 8'h66);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    cs_base = cs_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_rsp", {bus.rsp_err, bus.rsp_rdata}, {1'b0, 8'h5F});
      step();
    end
    check("bp_no_cs", 32'(cs_cnt - cs_base), 0);
    bus.rsp_ready = 1'b1;
    wait_q(2);
    expect_rsp("bp_rd5_rsp", 1'b0, 8'h5F);
    expect_rsp("bp_wr6_rsp", 1'b0, 8'h00);

    // Back-to-back alternating write/read over all addresses
    for (int i = 0; i < 8; i++) begin
      push(1'b1, 8'(i), 8'(8'hC0 + i));
      push(1'b0, 8'(i), 8'h00);
    end
    wait_q(16);
    for (int i = 0; i < 8; i++) begin
      expect_rsp("b2b_wr_rsp", 1'b0, 8'h00);
      expect_rsp("b2b_rd_rsp", 1'b0, 8'(8'hC0 + i));
    end
    check("we_rd_overlap", 32'(both_cnt), 0);

    // Reset in the middle of a read with a write still queued
    push(1'b0, 8'd1, 8'h00);
    push(1'b1, 8'd2, 8'hEE);
    n = 0;
    while (!bus.mem_RD && n < 20) begin
      step();
      n++;
    end
    check("mid_rd_active", bus.mem_RD, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_strobes", {bus.mem_CS, bus.mem_WE, bus.mem_RD}, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ready", bus.req_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_count", fifo_count, 0);
    check("post_valid", bus.rsp_valid, 0);
    check("post_ready", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) step();
    check("post_no_rsp", 32'(rsp_q.size()), 0);
    push(1'b0, 8'd2, 8'h00);
    wait_q(1);
    expect_rsp("post_rd2_rsp", 1'b0, 8'hC2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request-side controller that sits directly upstream of the team's single-port synchronous SRAM (CS/WE/RD strobes, registered read data). It accepts read/write requests on a valid/ready interface, buffers them in a small FIFO, and sequences them onto the SRAM pins one at a time. For every request it returns exactly one response carrying read data or an out-of-range error, with backpressure.

## Interface
Parameters:
- ADR, 8, address width (matches SRAM).
- DAT, 8, data width (matches SRAM).
- DPTH, 8, number of implemented SRAM words; addresses >= DPTH are errors.
- FDEPTH, 4, request FIFO depth (power of 2, >= 2).

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADR  request address.
- req_wdata  in  DAT  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DAT  read data; 0 for writes and errors.
- rsp_err  out  1  1 = address out of range, no SRAM access made.
- fifo_count  out  clog2(FDEPTH)+1  current FIFO occupancy.
- mem_CS, mem_WE, mem_RD  out  1 each  SRAM strobes.
- mem_Addr  out  ADR  SRAM address.
- mem_dataIn  out  DAT  SRAM write data.
- mem_dataOut  in  DAT  SRAM registered read data.

## Operation
- FIFO stores {we, addr, wdata}. Push on req_valid && req_ready; req_ready = !full (pure function of count; a pop in the same cycle does not open a slot). Pop only in IDLE.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE: if FIFO non-empty, pop head into command register (cmd_we, cmd_addr, cmd_wdata). Next state: RESP with err=1, rdata=0 if cmd addr >= DPTH; else WRITE if we; else READ. If empty, stay.
- WRITE: mem_CS=1, mem_WE=1, mem_RD=0 for exactly one cycle; SRAM writes at its end. Next: RESP, err=0, rdata=0.
- READ: mem_CS=1, mem_RD=1, mem_WE=0 for exactly one cycle; SRAM updates mem_dataOut at its end. Next: CAPTURE.
- CAPTURE: strobes 0; register mem_dataOut into rsp_rdata at end of cycle. Next: RESP, err=0.
- RESP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_valid && rsp_ready; then IDLE. No pop in RESP.
- Strobes are decoded from the state register only; all three are 0 in IDLE, CAPTURE, RESP. WE and RD never both 1.
- mem_Addr/mem_dataIn driven from the command register, holding the last value between accesses.
- Requests complete strictly in order; one outstanding SRAM access at a time.

## Timing
- Reset (async, Rst_n=0): state IDLE, FIFO empty, fifo_count=0, req_ready=0 while in reset then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0; all mem_* outputs 0. Strobes drop immediately on reset assertion.
- Reset mid-operation: queued and in-flight requests discarded with no response; a partially driven strobe is not completed; SRAM contents untouched.
- Latency from accept edge E0 into empty FIFO, idle FSM: pop at E1; write strobe cycle E1–E2, rsp_valid from E2; read strobe E1–E2, capture E2–E3, rsp_valid from E3; error rsp_valid from E1.
- Throughput with rsp_ready=1: write 3 cycles, read 4 cycles, error 2 cycles per request.
- Full FIFO: req_ready=0, req_valid ignored, no overwrite. Empty FIFO: FSM idles, no strobes.
- FIFO pointers wrap modulo FDEPTH; fifo_count saturates at neither end (push on full and pop on empty impossible by construction).

## Test plan
- Reset: Rst_n=0 mid-READ -> mem_RD, mem_CS fall to 0 immediately; after release, fifo_count=0, rsp_valid=0, req_ready=1.
- Write then read: write addr 3 data 0xA5, read addr 3 (rsp_ready=1) -> write response err=0 rdata=0x00 at E2; read response rdata=0xA5 err=0 at E3 after its pop.
- Out of range: read addr 8 (DPTH=8) -> rsp_err=1, rsp_rdata=0, no mem_CS pulse; following read addr 7 proceeds normally.
- FIFO full: hold rsp_ready=0, push 6 requests -> 1 popped into FSM, 4 queued, fifo_count=4, req_ready=0; 6th held until a pop.
- Backpressure: rsp_ready=0 for 5 cycles during read response -> rsp_valid and rsp_rdata stable, no new strobes; order preserved after release.
- Back-to-back alternating writes/reads to addrs 0..7 with wrap of FIFO pointers -> all read data match scoreboard, WE/RD never simultaneously 1.
